rect_fill_engine: RTL and testbench
===================================

Name: rect_fill_engine

Overview:
- Parametrised successor to the fixed 640x480 clear sweep in the top level.
- Fills any screen rectangle with a programmable colour, one pixel per clock. Start/busy/done handshake plus abort.
- Arbitrates a second pixel source (line drawer) onto the single framebuffer write port, so the top level no longer muxes clear and draw with a slow divided clock.
- Sits between line_drawer/control logic and VGA_framebuffer.

Parameters:
- X_W, 11, width of x coordinates
- Y_W, 11, width of y coordinates
- SCREEN_W, 640, visible columns; valid x is 0..SCREEN_W-1
- SCREEN_H, 480, visible rows; valid y is 0..SCREEN_H-1
- COLOR_W, 1, pixel colour width

Ports:
- clk  in  1  system clock (CLOCK_50 domain)
- reset  in  1  synchronous, active-high reset
- start  in  1  request a fill; sampled only in IDLE
- abort  in  1  cancel an in-progress fill
- x_min  in  X_W  rectangle left edge, inclusive
- y_min  in  Y_W  rectangle top edge, inclusive
- x_max  in  X_W  rectangle right edge, inclusive
- y_max  in  Y_W  rectangle bottom edge, inclusive
- fill_color  in  COLOR_W  colour for the fill
- draw_valid  in  1  draw client presents a pixel
- draw_x  in  X_W  draw pixel x
- draw_y  in  Y_W  draw pixel y
- draw_color  in  COLOR_W  draw pixel colour
- draw_ready  out  1  draw pixel accepted this cycle when draw_valid && draw_ready
- x  out  X_W  framebuffer write x (registered)
- y  out  Y_W  framebuffer write y (registered)
- pixel_color  out  COLOR_W  framebuffer write colour (registered)
- pixel_write  out  1  framebuffer write strobe (registered)
- busy  out  1  high in FILL and DONE states
- done  out  1  one-cycle pulse when a fill completes normally

Behaviour:
- Reset values:
  - State is IDLE.
  - x, y, pixel_color, pixel_write, busy and done are all 0.
  - Reset mid-fill abandons the fill at once. No done pulse.
- States: IDLE, FILL, DONE.
- IDLE:
  - draw_ready = !start (combinational). start has priority over a simultaneous draw beat; that draw beat is not accepted.
  - Accepted draw beat: registered to x/y/pixel_color next cycle, with pixel_write=1 only if draw_x<SCREEN_W and draw_y<SCREEN_H. Off-screen beats are consumed and dropped.
  - start=1: latch x_min, y_min, fill_color, clamped xe=min(x_max,SCREEN_W-1) and ye=min(y_max,SCREEN_H-1). Set cursor to (x_min,y_min).
  - If x_min>xe or y_min>ye, go to DONE (empty fill, zero writes). Otherwise go to FILL.
- FILL:
  - draw_ready=0.
  - Each cycle, register the cursor to x/y with pixel_color=latched colour and pixel_write=1.
  - Raster order: x increments first. When x=xe, x returns to x_min and y increments.
  - After the write of (xe,ye), go to DONE.
  - Writes per fill = (xe-x_min+1)*(ye-y_min+1), back-to-back with no gaps.
  - First write is registered at the edge after start is sampled, so it is visible one cycle after start.
- DONE:
  - Lasts exactly one cycle. pixel_write=0, done=1, then return to IDLE.
  - Edges that land exactly on the clamp limit are legal and produce no wrap error.
- abort=1 in FILL:
  - The next edge goes to IDLE with pixel_write=0.
  - No done pulse. Pixels already written stay written.
  - abort in IDLE or DONE has no effect.
- start while busy is ignored. Inputs are not re-latched mid-fill.
- Counter arithmetic is done at X_W/Y_W width. The cursor never exceeds xe/ye, so there is no overflow.

Test Plan:
- Reset, then start with (0,0)-(639,479), colour 0 -> 307200 consecutive writes in raster order. First write (0,0), last (639,479). done pulses the cycle after the last write. busy is high throughout. No write lands at x=640 or y=480.
- Start with (2,3)-(4,4), colour 1 -> exactly 6 writes in the order (2,3),(3,3),(4,3),(2,4),(3,4),(4,4). Then done for one cycle, then IDLE with draw_ready=1.
- Start with (630,470)-(700,500) -> clamped to (630..639, 470..479), giving 100 writes. Start with (10,5)-(9,5) -> zero writes, done one cycle after start.
- Pass-through while idle:
  - draw_valid with (100,50,1) -> pixel_write=1, x=100, y=50 next cycle.
  - draw_valid with (640,10) -> accepted but pixel_write=0.
  - start and draw_valid in the same cycle -> draw_ready=0 and the fill wins.
- abort asserted on the 5th fill write of (0,0)-(9,9) -> exactly 5 writes, pixel_write low afterwards, no done pulse. A following start is accepted normally.
- reset pulsed mid-fill -> all outputs are 0 next cycle and the state is IDLE. A subsequent draw beat passes through correctly.

Source files
------------

// File: rtl/rect_fill_engine.sv
// Rectangle fill engine with draw-port arbitration onto one framebuffer write port.
// Ports: clk/reset, start/abort/rect/fill_color in, draw_* handshake in, x/y/pixel_color/pixel_write/busy/done out.
module rect_fill_engine #(
    parameter int X_W      = 11,
    parameter int Y_W      = 11,
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int COLOR_W  = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [X_W-1:0]     x_min,
    input  logic [Y_W-1:0]     y_min,
    input  logic [X_W-1:0]     x_max,
    input  logic [Y_W-1:0]     y_max,
    input  logic [COLOR_W-1:0] fill_color,
    input  logic               draw_valid,
    input  logic [X_W-1:0]     draw_x,
    input  logic [Y_W-1:0]     draw_y,
    input  logic [COLOR_W-1:0] draw_color,
    output logic               draw_ready,
    output logic [X_W-1:0]     x,
    output logic [Y_W-1:0]     y,
    output logic [COLOR_W-1:0] pixel_color,
    output logic               pixel_write,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

    localparam logic [X_W-1:0] X_LIM = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(SCREEN_H - 1);

    state_t state, state_nx;

    logic [X_W-1:0]     x_lo, x_hi, xe_c;
    logic [Y_W-1:0]     y_hi, ye_c;
    logic [COLOR_W-1:0] color_q;
    logic               empty, last, draw_fire, on_screen;

    assign xe_c      = (x_max > X_LIM) ? X_LIM : x_max;
    assign ye_c      = (y_max > Y_LIM) ? Y_LIM : y_max;
    assign empty     = (x_min > xe_c) || (y_min > ye_c);
    // x/y double as the fill cursor: they always hold the pixel on the bus.
    assign last      = (x == x_hi) && (y == y_hi);
    assign draw_fire = draw_valid && draw_ready;
    assign on_screen = (draw_x <= X_LIM) && (draw_y <= Y_LIM);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: if (start) state_nx = empty ? DONE : FILL;
            FILL: begin
                if (abort)     state_nx = IDLE;
                else if (last) state_nx = DONE;
            end
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        draw_ready = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: draw_ready = !start;
            FILL: busy = 1'b1;
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            x           <= '0;
            y           <= '0;
            pixel_color <= '0;
            pixel_write <= 1'b0;
            x_lo        <= '0;
            x_hi        <= '0;
            y_hi        <= '0;
            color_q     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        x_lo        <= x_min;
                        x_hi        <= xe_c;
                        y_hi        <= ye_c;
                        color_q     <= fill_color;
                        x           <= x_min;
                        y           <= y_min;
                        pixel_color <= fill_color;
                        pixel_write <= !empty;
                    end else if (draw_fire) begin
                        x           <= draw_x;
                        y           <= draw_y;
                        pixel_color <= draw_color;
                        pixel_write <= on_screen;
                    end else begin
                        pixel_write <= 1'b0;
                    end
                end
                FILL: begin
                    if (abort || last) begin
                        pixel_write <= 1'b0;
                    end else begin
                        pixel_write <= 1'b1;
                        pixel_color <= color_q;
                        if (x == x_hi) begin
                            x <= x_lo;
                            y <= y + Y_W'(1);
                        end else begin
                            x <= x + X_W'(1);
                        end
                    end
                end
                default: pixel_write <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill_engine.sv
// Directed bench for rect_fill_engine: fills, clamping, pass-through, abort, reset.
// Expected write streams come from a raster model held in the bench.
module tb_rect_fill_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic        start, abort;
    logic [10:0] x_min, y_min, x_max, y_max;
    logic [0:0]  fill_color;
    logic        draw_valid;
    logic [10:0] draw_x, draw_y;
    logic [0:0]  draw_color;
    logic        draw_ready;
    logic [10:0] x, y;
    logic [0:0]  pixel_color;
    logic        pixel_write, busy, done;

    int n_chk  = 0;
    int n_pass = 0;

    rect_fill_engine dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .x_min(x_min), .y_min(y_min), .x_max(x_max), .y_max(y_max),
        .fill_color(fill_color), .draw_valid(draw_valid),
        .draw_x(draw_x), .draw_y(draw_y), .draw_color(draw_color),
        .draw_ready(draw_ready), .x(x), .y(y), .pixel_color(pixel_color),
        .pixel_write(pixel_write), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rect(input int x0, input int y0, input int x1,
                            input int y1, input int col);
        x_min      = 11'(x0);
        y_min      = 11'(y0);
        x_max      = 11'(x1);
        y_max      = 11'(y1);
        fill_color = 1'(col);
    endtask

    // Starts a fill and checks the whole write stream against a raster model.
    task automatic run_fill(input string tag, input int x0, input int y0,
                            input int x1, input int y1, input int col,
                            input bit with_draw);
        int xe, ye, n_exp, n_got, errs, ex, ey, cyc;
        bit seen_done;
        xe    = (x1 > 639) ? 639 : x1;
        ye    = (y1 > 479) ? 479 : y1;
        n_exp = (x0 > xe || y0 > ye) ? 0 : (xe - x0 + 1) * (ye - y0 + 1);
        set_rect(x0, y0, x1, y1, col);
        start = 1'b1;
        if (with_draw) begin
            draw_valid = 1'b1;
            draw_x     = 11'd7;
            draw_y     = 11'd7;
            draw_color = 1'b0;
            #1;
            chk({tag, " draw_ready vs start"}, int'(draw_ready), 0);
        end
        step();
        start      = 1'b0;
        draw_valid = 1'b0;
        n_got = 0;
        errs  = 0;
        ex    = x0;
        ey    = y0;
        seen_done = 1'b0;
        for (cyc = 1; cyc <= n_exp + 10; cyc++) begin
            if (done) begin
                seen_done = 1'b1;
                break;
            end
            if (!busy || draw_ready) errs++;
            if (pixel_write) begin
                if (int'(x) != ex || int'(y) != ey || int'(pixel_color) != col)
                    errs++;
                n_got++;
                if (ex == xe) begin
                    ex = x0;
                    ey++;
                end else begin
                    ex++;
                end
            end else begin
                errs++;
            end
            step();
        end
        chk({tag, " done seen"}, int'(seen_done), 1);
        chk({tag, " done cycle"}, cyc, n_exp + 1);
        chk({tag, " write count"}, n_got, n_exp);
        chk({tag, " order/colour errs"}, errs, 0);
        chk({tag, " write in DONE"}, int'(pixel_write), 0);
        step();
        chk({tag, " done one cycle"}, int'(done), 0);
        chk({tag, " idle busy"}, int'(busy), 0);
        chk({tag, " idle draw_ready"}, int'(draw_ready), 1);
    endtask

    initial begin
        int n_got;
        bit done_seen;
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        draw_valid = 1'b0;
        draw_x     = '0;
        draw_y     = '0;
        draw_color = '0;
        set_rect(0, 0, 0, 0, 0);
        step();
        step();
        chk("rst x", int'(x), 0);
        chk("rst y", int'(y), 0);
        chk("rst pixel_write", int'(pixel_write), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        reset = 1'b0;
        step();
        chk("idle draw_ready", int'(draw_ready), 1);

        run_fill("small", 2, 3, 4, 4, 1, 1'b0);
        run_fill("clamp", 630, 470, 700, 500, 1, 1'b0);
        run_fill("empty", 10, 5, 9, 5, 1, 1'b0);
        run_fill("edge", 0, 478, 639, 479, 0, 1'b0);
        run_fill("start+draw", 2, 3, 4, 4, 1, 1'b1);

        draw_valid = 1'b1;
        draw_x     = 11'd100;
        draw_y     = 11'd50;
        draw_color = 1'b1;
        #1;
        chk("pt draw_ready", int'(draw_ready), 1);
        step();
        chk("pt write", int'(pixel_write), 1);
        chk("pt x", int'(x), 100);
        chk("pt y", int'(y), 50);
        chk("pt colour", int'(pixel_color), 1);
        draw_x = 11'd640;
        draw_y = 11'd10;
        step();
        chk("offscreen x write", int'(pixel_write), 0);
        draw_x = 11'd10;
        draw_y = 11'd480;
        step();
        chk("offscreen y write", int'(pixel_write), 0);
        draw_valid = 1'b0;
        step();
        chk("no beat write", int'(pixel_write), 0);

        set_rect(0, 0, 9, 9, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        n_got = 0;
        for (int i = 0; i < 20 && n_got < 5; i++) begin
            if (pixel_write) n_got++;
            if (n_got < 5) step();
        end
        chk("abort 5th at x", int'(x), 4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort write", int'(pixel_write), 0);
        chk("abort busy", int'(busy), 0);
        chk("abort done", int'(done), 0);
        done_seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (done || pixel_write) done_seen = 1'b1;
            step();
        end
        chk("abort quiet after", int'(done_seen), 0);
        run_fill("after abort", 2, 3, 4, 4, 1, 1'b0);

        set_rect(0, 0, 9, 9, 1);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst x", int'(x), 0);
        chk("midrst y", int'(y), 0);
        chk("midrst colour", int'(pixel_color), 0);
        chk("midrst write", int'(pixel_write), 0);
        chk("midrst busy", int'(busy), 0);
        chk("midrst done", int'(done), 0);
        chk("midrst draw_ready", int'(draw_ready), 1);
        draw_valid = 1'b1;
        draw_x     = 11'd5;
        draw_y     = 11'd6;
        draw_color = 1'b1;
        step();
        draw_valid = 1'b0;
        chk("post rst write", int'(pixel_write), 1);
        chk("post rst x", int'(x), 5);
        chk("post rst y", int'(y), 6);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
